restador_serial: RTL and testbench

//  Bit-serial N-bit subtractor for the ALU arithmetic group. Computes diff = a - b
//  LSB-first, one bit per clock, through one 1-bit full subtractor and a borrow flop.

---
 rtl/alu_pkg.sv | 13 +
 rtl/restador_1bit.sv | 13 +
 rtl/restador_serial.sv | 145 ++++++++++++++
 tb/tb_restador_serial.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU arithmetic-group definitions: default operand width and the
// serial subtractor state encoding.
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sub_state_t;

endpackage

// File: rtl/restador_1bit.sv
// Combinational 1-bit full subtractor: diff = a - b - borrow_in.
module restador_1bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/restador_serial.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first) with start/busy/done handshake.
// Optional flag outputs (Z/N/V) are built only when SERIAL_SUB_FLAGS_EN is defined.
module restador_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int unsigned CW = $clog2(WIDTH);

  sub_state_t       r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_sh, r_diff;
  logic             r_bin, r_bout, r_busy, r_done;
  logic             w_d, w_bout, w_accept, w_last;

  restador_1bit u_fs (
    .a          (r_a[0]),
    .b          (r_b[0]),
    .borrow_in  (r_bin),
    .diff       (w_d),
    .borrow_out (w_bout)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next   = SHIFT;
          w_accept = 1'b1;
        end
      end
      SHIFT: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        if (start) begin
          w_next   = SHIFT;
          w_accept = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Result registers load only on the final shift edge, so diff/borrow_out
  // stay stable while a following operation is shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sh   <= '0;
      r_diff <= '0;
      r_cnt  <= '0;
      r_bin  <= 1'b0;
      r_bout <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == SHIFT);
      r_done <= (w_next == DONE);
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_bin <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == SHIFT) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_bin <= w_bout;
        r_cnt <= r_cnt + CW'(1);
        r_sh  <= {w_d, r_sh[WIDTH-1:1]};
        if (w_last) begin
          r_diff <= {w_d, r_sh[WIDTH-1:1]};
          r_bout <= w_bout;
        end
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_bout;

`ifdef SERIAL_SUB_FLAGS_EN
  logic r_am, r_bm, r_nz, r_fz, r_fn, r_fv;

  // Operand MSBs are kept from acceptance since r_a/r_b are shifted away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_am <= 1'b0;
      r_bm <= 1'b0;
      r_nz <= 1'b0;
      r_fz <= 1'b0;
      r_fn <= 1'b0;
      r_fv <= 1'b0;
    end else if (w_accept) begin
      r_am <= a[WIDTH-1];
      r_bm <= b[WIDTH-1];
      r_nz <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_nz <= r_nz | w_d;
      if (w_last) begin
        r_fz <= ~(r_nz | w_d);
        r_fn <= w_d;
        r_fv <= (r_am ^ r_bm) & (r_am ^ w_d);
      end
    end
  end

  assign flag_z = r_fz;
  assign flag_n = r_fn;
  assign flag_v = r_fv;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_restador_serial.sv
// Self-checking bench for restador_serial (WIDTH=4): vector table, hand-written
// corner sequences and randomized operations against an arithmetic reference model.
module tb_restador_serial;

  localparam int unsigned W = 4;
`ifdef SERIAL_SUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow_out, flag_z, flag_n, flag_v;
  logic [W-1:0] diff;

  int n_pass = 0;
  int n_tot  = 0;
  logic [W-1:0] last_diff = '0;
  logic         last_bout = 1'b0;

  restador_serial #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_v     (flag_v)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo, z, n, v;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: unsigned modulo difference and signed range test on plain ints.
  function automatic void model(input int ta, input int tb, output logic [W-1:0] d,
                                output logic bo, output logic z, output logic n,
                                output logic v);
    int sa, sb, sd, m;
    m  = 1 << W;
    d  = W'((ta - tb + m) % m);
    bo = (ta < tb);
    z  = (((ta - tb + m) % m) == 0);
    n  = (((ta - tb + m) % m) >= (m / 2));
    sa = (ta >= m / 2) ? ta - m : ta;
    sb = (tb >= m / 2) ? tb - m : tb;
    sd = sa - sb;
    v  = (sd < -(m / 2)) || (sd > (m / 2) - 1);
  endfunction

  // Called at a falling edge; returns at the falling edge in which done is high.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic [W-1:0] ed, input logic eb, input logic ez,
                       input logic en, input logic ev, input string tag);
    int lat, nbusy;
    bit seen;
    start = 1'b1;
    a = ta;
    b = tb;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 1;
    nbusy = 0;
    seen = 1'b0;
    while (!seen && lat <= 3 * W) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) nbusy++;
        if (lat == W) chk({tag, "_hold_diff"}, 32'(diff), 32'(last_diff));
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(W + 1));
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(W));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'(0));
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
    chk({tag, "_flags"}, 32'({flag_z, flag_n, flag_v}),
        32'(FLAGS ? {ez, en, ev} : 3'b000));
    last_diff = ed;
    last_bout = eb;
  endtask

  initial begin
    logic [W-1:0] md;
    logic mb, mz, mn, mv;
    int ndone;

    tbl[0] = '{4'd5, 4'd3, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'd3, 4'd5, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{4'b1000, 4'd1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{4'd7, 4'd7, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{4'd0, 4'd1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{4'd15, 4'd0, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    chk("reset_outputs", 32'({busy, done, diff, borrow_out, flag_z, flag_n, flag_v}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_busy", 32'({busy, done}), 32'(0));

    // Table entries run back-to-back: each new start is held in the done cycle.
    foreach (tbl[i])
      do_op(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo, tbl[i].z, tbl[i].n, tbl[i].v,
            $sformatf("vec%0d", i));
    @(negedge clk);
    chk("idle_after_table", 32'({busy, done}), 32'(0));

    // start toggling and operand changes while busy must be ignored
    start = 1'b1;
    a = 4'd5;
    b = 4'd3;
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        start = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) ndone++;
    end
    chk("toggle_done_count", 32'(ndone), 32'(1));
    chk("toggle_diff", 32'(diff), 32'(2));
    chk("toggle_borrow", 32'(borrow_out), 32'(0));
    chk("toggle_idle", 32'(busy), 32'(0));
    last_diff = 4'd2;
    last_bout = 1'b0;

    // reset in the second SHIFT cycle, after a nonzero result was held
    do_op(4'd15, 4'd0, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, "pre_rst");
    @(negedge clk);
    start = 1'b1;
    a = 4'd9;
    b = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midop_reset_outputs",
        32'({busy, done, diff, borrow_out, flag_z, flag_n, flag_v}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("no_done_after_reset", 32'(ndone), 32'(0));
    last_diff = '0;
    last_bout = 1'b0;
    do_op(4'd9, 4'd2, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst");

    for (int r = 0; r < 40; r++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      model(int'(ra), int'(rb), md, mb, mz, mn, mv);
      do_op(ra, rb, md, mb, mz, mn, mv, $sformatf("rnd%0d", r));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
